// File: rtl/ftop_msoc_info_pkg.sv
// Shared types and defaults for the info RAM streamer.
// State encoding plus width and depth defaults used by every file.
package ftop_msoc_info_pkg;

    localparam int INFO_ADDR_W     = 8;
    localparam int INFO_DATA_W     = 32;
    localparam int INFO_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

endpackage

// File: rtl/ftop_msoc_info_fifo.sv
// Small synchronous FIFO carrying stream payload plus sop/eop tags.
// Flush empties it in one cycle and wins over a same-cycle push or pop.
module ftop_msoc_info_fifo
    import ftop_msoc_info_pkg::*;
#(
    parameter int DATA_W = INFO_DATA_W,
    parameter int DEPTH  = INFO_FIFO_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              push_sop,
    input  logic              push_eop,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output logic              head_sop,
    output logic              head_eop,
    output logic [CNT_W-1:0]  count
);

    logic [DATA_W+1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign do_push = push && (count != CNT_W'(DEPTH));
    assign do_pop  = pop && (count != '0);

    assign {head_sop, head_eop, head_data} = mem[rd_ptr];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Entry storage; contents only matter where count says so.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= {push_sop, push_eop, push_data};
    end

endmodule

// File: rtl/ftop_msoc_info_streamer.sv
// Reads a block of words from the info RAM and streams them out.
// Reads are throttled so FIFO entries plus in-flight reads never exceed depth.
module ftop_msoc_info_streamer
    import ftop_msoc_info_pkg::*;
#(
    parameter int ADDR_W     = INFO_ADDR_W,
    parameter int DATA_W     = INFO_DATA_W,
    parameter int FIFO_DEPTH = INFO_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W:0]   len,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_readdata,
    output logic [DATA_W-1:0] st_data,
    output logic              st_valid,
    input  logic              st_ready,
    output logic              st_sop,
    output logic              st_eop
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   rem_q;
    logic              first_q;
    logic              infl_q;
    logic              infl_sop_q;
    logic              infl_eop_q;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W-1:0]  occ;
    logic              active;
    logic              issue;
    logic              last_issue;
    logic              pop;
    logic              flush;
    logic              drained;
    logic              head_sop;
    logic              head_eop;

    assign active     = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign occ        = fifo_count + CNT_W'(infl_q);
    assign issue      = (state_q == S_RUN) && !abort && !reset
                        && (occ < CNT_W'(FIFO_DEPTH));
    assign last_issue = issue && (rem_q == (ADDR_W+1)'(1));
    assign st_valid   = (fifo_count != '0);
    assign pop        = st_valid && st_ready;
    assign flush      = active && abort;
    // Finish as soon as the final beat leaves, not a cycle later.
    assign drained    = !infl_q && ((fifo_count == '0)
                        || ((fifo_count == CNT_W'(1)) && pop));

    assign busy           = (state_q != S_IDLE);
    assign done           = (state_q == S_DONE);
    assign mem_address    = addr_q;
    assign mem_chipselect = issue;
    assign mem_write      = 1'b0;
    assign st_sop         = st_valid && head_sop;
    assign st_eop         = st_valid && head_eop;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; abort jumps straight to DONE from RUN or DRAIN.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) state_d = (len == '0) ? S_DONE : S_RUN;
            end
            S_RUN: begin
                if (abort)           state_d = S_DONE;
                else if (last_issue) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (abort)        state_d = S_DONE;
                else if (drained) state_d = S_DONE;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Read address generation and one-deep in-flight tracking.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q     <= '0;
            rem_q      <= '0;
            first_q    <= 1'b0;
            infl_q     <= 1'b0;
            infl_sop_q <= 1'b0;
            infl_eop_q <= 1'b0;
        end else begin
            if (state_q == S_IDLE && start) begin
                addr_q  <= base;
                rem_q   <= len;
                first_q <= 1'b1;
            end else if (issue) begin
                addr_q  <= addr_q + ADDR_W'(1);
                rem_q   <= rem_q - (ADDR_W+1)'(1);
                first_q <= 1'b0;
            end
            infl_q     <= issue;
            infl_sop_q <= issue && first_q;
            infl_eop_q <= last_issue;
        end
    end

    ftop_msoc_info_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .push      (infl_q),
        .push_data (mem_readdata),
        .push_sop  (infl_sop_q),
        .push_eop  (infl_eop_q),
        .pop       (pop),
        .head_data (st_data),
        .head_sop  (head_sop),
        .head_eop  (head_eop),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_ftop_msoc_info_streamer.sv
// Scoreboard bench for the info streamer.
// Stimulus queues expected addresses and beats; a negedge monitor checks them.
module tb_ftop_msoc_info_streamer;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int FD = 4;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          sop;
        logic          eop;
    } beat_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] base;
    logic [AW:0]   len;
    logic          abort;
    logic          busy;
    logic          done;
    logic [AW-1:0] mem_address;
    logic          mem_chipselect;
    logic          mem_write;
    logic [DW-1:0] mem_readdata = '0;
    logic [DW-1:0] st_data;
    logic          st_valid;
    logic          st_ready;
    logic          st_sop;
    logic          st_eop;

    int checks = 0;
    int passes = 0;
    int beats = 0;
    int done_seen = 0;

    beat_t         exp_beat[$];
    logic [AW-1:0] exp_addr[$];

    always #5 clk = ~clk;

    ftop_msoc_info_streamer #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .FIFO_DEPTH (FD)
    ) u_dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .base           (base),
        .len            (len),
        .abort          (abort),
        .busy           (busy),
        .done           (done),
        .mem_address    (mem_address),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_readdata   (mem_readdata),
        .st_data        (st_data),
        .st_valid       (st_valid),
        .st_ready       (st_ready),
        .st_sop         (st_sop),
        .st_eop         (st_eop)
    );

    function automatic logic [DW-1:0] word(input logic [AW-1:0] a);
        return {8'hC0, a, ~a, a};
    endfunction

    always @(posedge clk) begin
        if (mem_chipselect) mem_readdata <= word(mem_address);
    end

    task automatic chk(input bit ok, input string name,
                       input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (ok) passes++;
        else $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    endtask

    logic          prev_v = 1'b0;
    logic          prev_r = 1'b0;
    logic          prev_a = 1'b0;
    logic [DW-1:0] prev_d = '0;

    always @(negedge clk) begin
        if (reset) begin
            prev_v = 1'b0;
        end else begin
            if (mem_chipselect) begin
                chk(exp_addr.size() != 0, "addr_unexpected",
                    64'(mem_address), 64'(0));
                if (exp_addr.size() != 0) begin
                    logic [AW-1:0] ea;
                    ea = exp_addr.pop_front();
                    chk(mem_address == ea, "addr", 64'(mem_address), 64'(ea));
                end
            end
            if (st_valid && st_ready) begin
                chk(exp_beat.size() != 0, "beat_unexpected",
                    64'(st_data), 64'(0));
                if (exp_beat.size() != 0) begin
                    beat_t eb;
                    eb = exp_beat.pop_front();
                    chk(st_data == eb.data && st_sop == eb.sop
                        && st_eop == eb.eop, "beat",
                        {30'd0, st_sop, st_eop, st_data},
                        {30'd0, eb.sop, eb.eop, eb.data});
                end
                beats++;
            end
            if (prev_v && !prev_r && !prev_a)
                chk(st_valid && st_data == prev_d, "stall_hold",
                    {31'd0, st_valid, st_data}, {32'd1, prev_d});
            if (st_valid && !st_ready)
                chk(u_dut.fifo_count <= FD, "fifo_occupancy",
                    64'(u_dut.fifo_count), 64'(FD));
            if (done) done_seen++;
            prev_v = st_valid;
            prev_r = st_ready;
            prev_a = abort;
            prev_d = st_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [AW-1:0] b, input int n);
        base  = b;
        len   = (AW+1)'(n);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic push_transfer(input logic [AW-1:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            logic [AW-1:0] a;
            a = b + AW'(i);
            exp_addr.push_back(a);
            exp_beat.push_back('{word(a), i == 0, i == n - 1});
        end
    endtask

    task automatic wait_done(input string name, input int max);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < max && !seen; i++) begin
            tick();
            seen = done;
        end
        chk(seen, name, 64'(seen), 64'(1));
    endtask

    task automatic chk_idle_outputs(input string name);
        chk({busy, done, mem_chipselect, mem_address,
             st_valid, st_sop, st_eop, mem_write} == '0, name,
            64'({busy, done, mem_chipselect, mem_address,
                 st_valid, st_sop, st_eop, mem_write}), 64'(0));
    endtask

    task automatic chk_drained(input string name);
        chk(exp_beat.size() == 0 && exp_addr.size() == 0, name,
            64'(exp_beat.size()), 64'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bit [3:0] pat;
        int b0;
        pat      = 4'b1001;
        reset    = 1'b1;
        start    = 1'b0;
        base     = '0;
        len      = '0;
        abort    = 1'b0;
        st_ready = 1'b1;
        repeat (3) tick();
        chk_idle_outputs("reset_state");
        reset = 1'b0;
        tick();

        // base 0x10, len 4, ready held high
        exp_addr.push_back(8'h10); exp_addr.push_back(8'h11);
        exp_addr.push_back(8'h12); exp_addr.push_back(8'h13);
        exp_beat.push_back('{32'hC010EF10, 1'b1, 1'b0});
        exp_beat.push_back('{32'hC011EE11, 1'b0, 1'b0});
        exp_beat.push_back('{32'hC012ED12, 1'b0, 1'b0});
        exp_beat.push_back('{32'hC013EC13, 1'b0, 1'b1});
        do_start(8'h10, 4);
        chk(busy, "busy_after_start", 64'(busy), 64'(1));
        tick();
        chk(!st_valid, "valid_at_start+2", 64'(st_valid), 64'(0));
        tick();
        chk(st_valid && st_sop, "first_valid_at_start+3",
            64'({st_valid, st_sop}), 64'(3));
        repeat (3) tick();
        chk(st_eop && !done, "eop_beat3", 64'({st_eop, done}), 64'(2));
        tick();
        chk(done, "done_after_eop", 64'(done), 64'(1));
        tick();
        chk(!busy && !done, "idle_after_done", 64'({busy, done}), 64'(0));
        chk_drained("t1_drained");

        // address wrap 0xFE..0x01, plus a start while busy
        exp_addr.push_back(8'hFE); exp_addr.push_back(8'hFF);
        exp_addr.push_back(8'h00); exp_addr.push_back(8'h01);
        exp_beat.push_back('{32'hC0FE01FE, 1'b1, 1'b0});
        exp_beat.push_back('{32'hC0FF00FF, 1'b0, 1'b0});
        exp_beat.push_back('{32'hC000FF00, 1'b0, 1'b0});
        exp_beat.push_back('{32'hC001FE01, 1'b0, 1'b1});
        do_start(8'hFE, 4);
        tick();
        do_start(8'h40, 5);
        wait_done("t2_done", 30);
        tick();
        chk_drained("t2_drained");

        // len 8 with ready toggling 1,0,0,1
        push_transfer(8'h80, 8);
        do_start(8'h80, 8);
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 200 && !seen; i++) begin
                st_ready = pat[i % 4];
                tick();
                seen = done;
            end
            chk(seen, "t3_done", 64'(seen), 64'(1));
        end
        st_ready = 1'b1;
        tick();
        chk_drained("t3_drained");

        // len 0: done pulse next cycle, no reads, no beats
        do_start(8'h33, 0);
        chk(done && !st_valid && !mem_chipselect, "len0_done",
            64'({done, st_valid, mem_chipselect}), 64'(4));
        tick();
        chk(!done && !busy, "len0_idle", 64'({done, busy}), 64'(0));

        // len 256 aborted after 10 beats, then a fresh transfer
        push_transfer(8'h00, 256);
        b0 = beats;
        do_start(8'h00, 256);
        for (int i = 0; i < 100 && (beats - b0) < 10; i++) tick();
        chk(beats - b0 == 10, "t5_ten_beats", 64'(beats - b0), 64'(10));
        st_ready = 1'b0;
        abort    = 1'b1;
        tick();
        abort    = 1'b0;
        st_ready = 1'b1;
        chk(!st_valid && done, "abort_valid_low_done",
            64'({st_valid, done}), 64'(1));
        exp_beat.delete();
        exp_addr.delete();
        tick();
        push_transfer(8'h20, 2);
        do_start(8'h20, 2);
        wait_done("post_abort_done", 30);
        tick();
        chk_drained("t5_drained");

        // reset in the middle of a transfer
        push_transfer(8'h50, 8);
        do_start(8'h50, 8);
        repeat (4) tick();
        st_ready = 1'b0;
        reset    = 1'b1;
        tick();
        chk_idle_outputs("reset_mid_transfer");
        reset = 1'b0;
        exp_beat.delete();
        exp_addr.delete();
        st_ready = 1'b1;
        tick();
        chk(!done && !busy, "no_done_after_reset", 64'({done, busy}), 64'(0));

        // single beat carries both sop and eop
        push_transfer(8'h7F, 1);
        do_start(8'h7F, 1);
        wait_done("len1_done", 20);
        tick();
        chk_drained("len1_drained");
        chk(done_seen == 7, "done_pulse_count", 64'(done_seen), 64'(7));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
